// File: rtl/lockable_reg_access_ctrl.sv
// Write controller for lock-protected config registers: round-robin host/debug arbitration,
// fixed IDLE->CHECK->COMMIT->RESP sequence. Define DEBUG_OVERRIDE_EN to let unlocked debug writes bypass locks.
module lockable_reg_access_ctrl #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2
) (
   input  logic                       clk_i,
   input  logic                       resetn_i,
   // Handshake: req is a level held with addr/wdata/lock until ack; ack is a one-cycle
   // pulse with err valid alongside it; a req still high in IDLE starts a new write.
   input  logic                       h_req_i,
   input  logic [ADDR_W-1:0]          h_addr_i,
   input  logic [DATA_W-1:0]          h_wdata_i,
   input  logic                       h_lock_i,
   output logic                       h_ack_o,
   output logic                       h_err_o,
   input  logic                       d_req_i,
   input  logic [ADDR_W-1:0]          d_addr_i,
   input  logic [DATA_W-1:0]          d_wdata_i,
   input  logic                       d_lock_i,
   output logic                       d_ack_o,
   output logic                       d_err_o,
   input  logic                       debug_unlocked_i,
   output logic [NUM_REGS*DATA_W-1:0] reg_data_o,
   output logic [NUM_REGS-1:0]        lock_status_o,
   output logic                       busy_o,
   output logic [1:0]                 state_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_COMMIT, ST_RESP} state_t;

   state_t                     state_q, state_d;
   logic                       prio_dbg_q, prio_dbg_d;
   logic                       src_dbg_q, src_dbg_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [DATA_W-1:0]          wdata_q, wdata_d;
   logic                       set_lock_q, set_lock_d;
   logic                       allowed_q, allowed_d;
   logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]        locks_q, locks_d;
   logic                       h_ack_q, h_ack_d, h_err_q, h_err_d;
   logic                       d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic                       any_req, grant_dbg, addr_hit, addr_locked, override;

   assign any_req   = h_req_i | d_req_i;
   // prio_dbg_q set means debug was not granted most recently and wins a tie
   assign grant_dbg = d_req_i & (~h_req_i | prio_dbg_q);

   always_comb begin
      addr_hit    = 1'b0;
      addr_locked = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            addr_hit    = 1'b1;
            addr_locked = locks_q[i];
         end
      end
   end

`ifdef DEBUG_OVERRIDE_EN
   assign override = src_dbg_q & debug_unlocked_i & addr_hit;
`else
   logic unused_debug_unlocked;
   assign unused_debug_unlocked = debug_unlocked_i;
   assign override = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!resetn_i) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (any_req) state_d = ST_CHECK;
         ST_CHECK:  state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q != ST_IDLE);
      state_o = state_q;
   end

   always_comb begin
      prio_dbg_d = prio_dbg_q;
      src_dbg_d  = src_dbg_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      set_lock_d = set_lock_q;
      allowed_d  = allowed_q;
      regs_d     = regs_q;
      locks_d    = locks_q;
      h_ack_d    = 1'b0;
      d_ack_d    = 1'b0;
      h_err_d    = 1'b0;
      d_err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               src_dbg_d  = grant_dbg;
               prio_dbg_d = ~grant_dbg;
               addr_d     = grant_dbg ? d_addr_i  : h_addr_i;
               wdata_d    = grant_dbg ? d_wdata_i : h_wdata_i;
               set_lock_d = grant_dbg ? d_lock_i  : h_lock_i;
            end
         end
         ST_CHECK: allowed_d = (addr_hit & ~addr_locked) | override;
         ST_COMMIT: begin
            if (allowed_q) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                     regs_d[i*DATA_W +: DATA_W] = wdata_q;
                     locks_d[i]                 = locks_q[i] | set_lock_q;
                  end
               end
            end
            h_ack_d = ~src_dbg_q;
            d_ack_d = src_dbg_q;
            h_err_d = ~src_dbg_q & ~allowed_q;
            d_err_d = src_dbg_q & ~allowed_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         prio_dbg_q <= 1'b0;
         src_dbg_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         set_lock_q <= 1'b0;
         allowed_q  <= 1'b0;
         regs_q     <= '0;
         locks_q    <= '0;
         h_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         h_err_q    <= 1'b0;
         d_err_q    <= 1'b0;
      end else begin
         prio_dbg_q <= prio_dbg_d;
         src_dbg_q  <= src_dbg_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         set_lock_q <= set_lock_d;
         allowed_q  <= allowed_d;
         regs_q     <= regs_d;
         locks_q    <= locks_d;
         h_ack_q    <= h_ack_d;
         d_ack_q    <= d_ack_d;
         h_err_q    <= h_err_d;
         d_err_q    <= d_err_d;
      end
   end

   assign h_ack_o       = h_ack_q;
   assign h_err_o       = h_err_q;
   assign d_ack_o       = d_ack_q;
   assign d_err_o       = d_err_q;
   assign reg_data_o    = regs_q;
   assign lock_status_o = locks_q;
endmodule

// File: doc/lockable_reg_access_ctrl.md
# lockable_reg_access_ctrl

Write controller for a bank of lock-protected 16-bit configuration registers, shared between a host requester and a debug requester. It arbitrates the two requesters round-robin and serialises accepted writes through a fixed four-state sequence. Each write is checked against a per-register sticky lock bit before it commits. The block sits between the bus/debug front-ends and the lockable register storage, and is the sole writer of register data and lock state.

## Interface
- NUM_REGS, 4, number of lockable registers (2..16)
- DATA_W, 16, register width
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
- Clk  in  1  single clock, all state updates on posedge
- resetn  in  1  reset, synchronous and active-low
- h_req / d_req  in  1  host / debug write request, level, held until ack
- h_addr / d_addr  in  ADDR_W  target register index
- h_wdata / d_wdata  in  DATA_W  write data
- h_lock / d_lock  in  1  set the target's lock bit as part of this write
- h_ack / d_ack  out  1  one-cycle completion pulse
- h_err / d_err  out  1  valid with ack; 1 = write denied
- debug_unlocked  in  1  debug-mode indication (used only with the override feature)
- reg_data  out  NUM_REGS*DATA_W  register contents, register i at bits [i*DATA_W +: DATA_W]
- lock_status  out  NUM_REGS  per-register sticky lock bits
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE -> CHECK -> COMMIT -> RESP -> IDLE. No other transitions except reset.
- IDLE: requests are sampled only in this state. If no request is present, remain in IDLE.
  - Single request: it is granted.
  - Both requests: the requester not granted most recently wins. After reset the priority pointer favours host.
  - On grant: latch source, addr, wdata and lock flag; update the pointer; go to CHECK.
- CHECK: compute `allowed` and go to COMMIT.
  - allowed = (addr < NUM_REGS) & ~lock_status[addr], plus the override term described under Configuration.
  - An out-of-range address is always denied.
- COMMIT: if allowed, write wdata to reg_data[addr]. If allowed and the lock flag is set, set lock_status[addr] in the same edge. If denied, no state changes except the latched error flag.
- RESP: drive ack for the granted source only, with err = ~allowed. Return to IDLE.
- Requester protocol: hold req, addr, wdata and lock stable from assertion until ack; deassert req in the cycle after ack. A req still high in IDLE after ack is treated as a new transaction.
- Lock bits are set-only and cleared only by reset. No write path clears a lock, including the debug override.
- Writes do not modify any register other than the addressed one.

## Timing
- Reset (resetn=0 at a posedge):
  - FSM goes to IDLE; reg_data, lock_status, acks, errs and busy all go to 0; priority pointer goes to host.
  - An in-flight transaction is aborted with no ack and no commit.
- Latency: request sampled in IDLE at edge t. CHECK occupies t+1, COMMIT t+2, RESP t+3.
  - New reg_data/lock_status are visible from the RESP cycle.
  - ack/err are high for exactly the RESP cycle.
- Throughput: one transaction per 4 cycles. A waiting requester is granted no later than the next IDLE.
- Inputs are ignored outside IDLE; the values latched at grant are used throughout the transaction.
- debug_unlocked is sampled in CHECK only.
- ack and err are registered outputs, with no combinational path from inputs.

## Configuration
- DEBUG_OVERRIDE_EN defined: allowed additionally includes (source==debug & debug_unlocked & addr < NUM_REGS).
  - Debug writes then bypass lock bits while debug_unlocked is high.
  - This is the intentionally weakened variant used as a CWE-1234 fixture.
- DEBUG_OVERRIDE_EN undefined: lock bits are absolute for both sources, and debug_unlocked is unused.

## Test plan
- Reset, then host writes 16'hA5A5 to reg 1 with h_lock=0 -> h_ack at t+3, h_err=0, reg_data[1]=16'hA5A5, lock_status=4'b0000.
- Host writes 16'h1234 to reg 2 with h_lock=1, then writes 16'hFFFF to reg 2 -> first write succeeds and sets lock_status[2]=1; second gives h_err=1 and reg 2 stays 16'h1234.
- After reg 2 is locked, debug writes 16'hBEEF to reg 2 with debug_unlocked=1 -> with DEBUG_OVERRIDE_EN: d_err=0, reg 2=16'hBEEF, lock_status[2] stays 1; without: d_err=1, reg 2 unchanged.
- h_req and d_req asserted in the same cycle, held for two transactions each -> grant order host, debug, host, debug; each ack is a single pulse, never both in one cycle.
- With NUM_REGS=3, host writes to address 3 -> h_err=1, no register or lock changes.
- resetn=0 during COMMIT of a locking write -> no ack; all registers and locks read 0 on the next cycle; busy=0.
